// File: rtl/vote_pkg.sv
// Shared types and constants for the four-voter ballot sequencer.
package vote_pkg;

   localparam int N_VOTERS = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      TALLY   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [3:1] V_PASS = 3'b100;
   localparam logic [3:1] V_TIE  = 3'b010;
   localparam logic [3:1] V_FAIL = 3'b001;

endpackage

// File: rtl/vote_tally.sv
// Combinational tally: counts yes ballots among latched voters and classifies the count one-hot.
module vote_tally
   import vote_pkg::*;
(
   input  logic [N_VOTERS-1:0] ballots,
   input  logic [N_VOTERS-1:0] mask,
   output logic [2:0]          yes_cnt,
   output logic [3:1]          verdict
);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      yes_cnt = '0;
      verdict = V_FAIL;
      for (int i = 0; i < N_VOTERS; i++) begin
         yes_cnt = yes_cnt + {2'b00, ballots[i] & mask[i]};
      end
      if (yes_cnt >= 3'd3) begin
         verdict = V_PASS;
      end else if (yes_cnt == 3'd2) begin
         verdict = V_TIE;
      end
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot session sequencer: IDLE -> COLLECT -> TALLY -> DONE with registered one-hot verdict.
// Define VOTE_TIMEOUT_EN to close the collection window after TIMEOUT cycles.
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_val,
   output logic                busy,
   output logic                done,
   output logic [N_VOTERS-1:0] voted_mask,
   output logic [2:0]          yes_cnt,
   output logic [3:1]          O,
   output logic                timed_out
);

   state_t              state, state_nxt;
   logic [N_VOTERS-1:0] ballots;
   logic [N_VOTERS-1:0] fresh;
   logic [N_VOTERS-1:0] mask_nxt;
   logic                full;
   logic                expire;
   logic [2:0]          tally_yes;
   logic [3:1]          tally_verdict;

   // Only voters not yet in the mask may latch, so the first ballot wins.
   assign fresh    = vote_valid & ~voted_mask;
   assign mask_nxt = voted_mask | vote_valid;
   assign full     = &mask_nxt;

`ifdef VOTE_TIMEOUT_EN
   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (state == IDLE && start) begin
         timer <= '0;
      end else if (state == COLLECT) begin
         timer <= timer + TW'(1);
      end
   end

   assign expire = (timer == TW'(TIMEOUT - 1));
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT > 0) ^ (TW > 0);
   assign expire     = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COLLECT;
         COLLECT: if (full || expire) state_nxt = TALLY;
         TALLY:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == COLLECT) || (state == TALLY);
   assign done = (state == DONE);

   vote_tally u_tally (
      .ballots (ballots),
      .mask    (voted_mask),
      .yes_cnt (tally_yes),
      .verdict (tally_verdict)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ballots    <= '0;
         voted_mask <= '0;
         yes_cnt    <= '0;
         O          <= '0;
         timed_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ballots    <= '0;
                  voted_mask <= '0;
                  yes_cnt    <= '0;
                  O          <= '0;
                  timed_out  <= 1'b0;
               end
            end
            COLLECT: begin
               ballots    <= (ballots & ~fresh) | (vote_val & fresh);
               voted_mask <= mask_nxt;
               // A full mask takes priority over a coincident timeout.
               if (!full && expire) timed_out <= 1'b1;
            end
            TALLY: begin
               yes_cnt <= tally_yes;
               O       <= tally_verdict;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed self-checking bench for vote_session_ctrl; timeout scenarios run when VOTE_TIMEOUT_EN is defined.
module tb_vote_session_ctrl;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] vote_valid = '0;
   logic [3:0] vote_val = '0;
   logic       busy;
   logic       done;
   logic [3:0] voted_mask;
   logic [2:0] yes_cnt;
   logic [3:1] o;
   logic       timed_out;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   vote_session_ctrl #(.TIMEOUT(TO), .TW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .vote_valid (vote_valid),
      .vote_val   (vote_val),
      .busy       (busy),
      .done       (done),
      .voted_mask (voted_mask),
      .yes_cnt    (yes_cnt),
      .O          (o),
      .timed_out  (timed_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_session();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
   endtask

   task automatic step(input logic [3:0] v, input logic [3:0] b);
      vote_valid = v;
      vote_val   = b;
      tick();
      vote_valid = '0;
      vote_val   = '0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_done_wait got done=%b want 1 within %0d cycles", name, done, limit);
      end
   endtask

   task automatic test_reset();
      vote_valid = 4'hF;
      vote_val   = 4'hF;
      #12;
      n_cmp++;
      if ({busy, done, voted_mask, yes_cnt, o, timed_out} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got %b want 0", {busy, done, voted_mask, yes_cnt, o, timed_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (voted_mask !== 4'h0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_votes_ignored got mask=%b busy=%b want 0000 0", voted_mask, busy);
      end
      vote_valid = '0;
      vote_val   = '0;
   endtask

   task automatic test_all_yes();
      begin_session();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL ay_busy_c1 got %b want 1", busy); end
      step(4'hF, 4'hF);
      n_cmp++;
      if (voted_mask !== 4'hF || busy !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL ay_tally_c2 got mask=%b busy=%b done=%b want 1111 1 0", voted_mask, busy, done);
      end
      tick();
      n_cmp++;
      if ({done, busy, yes_cnt, o, timed_out} !== {1'b1, 1'b0, 3'd4, 3'b100, 1'b0}) begin
         n_bad++;
         $display("FAIL ay_done_c3 got done=%b busy=%b yes=%0d O=%b to=%b want 1 0 4 100 0",
                  done, busy, yes_cnt, o, timed_out);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || o !== 3'b100 || yes_cnt !== 3'd4) begin
         n_bad++;
         $display("FAIL ay_hold_c4 got done=%b O=%b yes=%0d want 0 100 4", done, o, yes_cnt);
      end
   endtask

   task automatic test_back_to_back();
      begin_session();
      n_cmp++;
      if ({o, yes_cnt, voted_mask, busy} !== {3'b000, 3'd0, 4'h0, 1'b1}) begin
         n_bad++;
         $display("FAIL b2b_clear got O=%b yes=%0d mask=%b busy=%b want 000 0 0000 1", o, yes_cnt, voted_mask, busy);
      end
      step(4'hF, 4'b0011);
      wait_done(4, "b2b");
      n_cmp++;
      if (cyc !== 3 || yes_cnt !== 3'd2 || o !== 3'b010) begin
         n_bad++;
         $display("FAIL b2b_result got cyc=%0d yes=%0d O=%b want 3 2 010", cyc, yes_cnt, o);
      end
      tick();
   endtask

   task automatic test_staggered();
      logic [3:0] vv [6];
      logic [3:0] vb [6];
      vv = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
      vb = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      begin_session();
      for (int c = 0; c < 6; c++) begin
         step(vv[c], vb[c]);
         if (c == 0) begin
            n_cmp++;
            if (voted_mask !== 4'b0001) begin
               n_bad++;
               $display("FAIL stag_mask_c2 got %b want 0001", voted_mask);
            end
         end
      end
      wait_done(4, "stag");
      n_cmp++;
      if ({yes_cnt, o, timed_out} !== {3'd2, 3'b010, 1'b0} || cyc !== 8) begin
         n_bad++;
         $display("FAIL stag_result got cyc=%0d yes=%0d O=%b to=%b want 8 2 010 0", cyc, yes_cnt, o, timed_out);
      end
      tick();
   endtask

   task automatic test_first_wins();
      begin_session();
      step(4'b0001, 4'b0001);
      step(4'b1111, 4'b0000);
      wait_done(4, "fw");
      n_cmp++;
      if ({yes_cnt, o, voted_mask} !== {3'd1, 3'b001, 4'hF} || cyc !== 4) begin
         n_bad++;
         $display("FAIL fw_result got cyc=%0d yes=%0d O=%b mask=%b want 4 1 001 1111", cyc, yes_cnt, o, voted_mask);
      end
      tick();
   endtask

`ifdef VOTE_TIMEOUT_EN
   task automatic test_timeout();
      begin_session();
      step(4'b0011, 4'b0011);
      wait_done(20, "to");
      n_cmp++;
      if ({timed_out, voted_mask, yes_cnt, o} !== {1'b1, 4'b0011, 3'd2, 3'b010} || cyc !== TO + 2) begin
         n_bad++;
         $display("FAIL to_result got cyc=%0d to=%b mask=%b yes=%0d O=%b want %0d 1 0011 2 010",
                  cyc, timed_out, voted_mask, yes_cnt, o, TO + 2);
      end
      tick();
   endtask

   task automatic test_full_on_timeout();
      begin_session();
      step(4'b0111, 4'b0100);
      for (int c = 2; c < TO; c++) step(4'b0000, 4'b0000);
      step(4'b1000, 4'b1000);
      wait_done(4, "fto");
      n_cmp++;
      if ({timed_out, voted_mask, yes_cnt, o} !== {1'b0, 4'hF, 3'd2, 3'b010} || cyc !== TO + 2) begin
         n_bad++;
         $display("FAIL fto_result got cyc=%0d to=%b mask=%b yes=%0d O=%b want %0d 0 1111 2 010",
                  cyc, timed_out, voted_mask, yes_cnt, o, TO + 2);
      end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      begin_session();
      step(4'b0001, 4'b0001);
      step(4'b0010, 4'b0010);
      n_cmp++;
      if (voted_mask !== 4'b0011 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rm_pre got mask=%b busy=%b want 0011 1", voted_mask, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, voted_mask, yes_cnt, o, timed_out} !== 13'd0) begin
         n_bad++;
         $display("FAIL rm_async got %b want 0", {busy, done, voted_mask, yes_cnt, o, timed_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      cyc = 1;
      step(4'hF, 4'b1000);
      tick();
      n_cmp++;
      if ({done, yes_cnt, o, voted_mask, timed_out} !== {1'b1, 3'd1, 3'b001, 4'hF, 1'b0}) begin
         n_bad++;
         $display("FAIL rm_clean got done=%b yes=%0d O=%b mask=%b to=%b want 1 1 001 1111 0",
                  done, yes_cnt, o, voted_mask, timed_out);
      end
      start = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || o !== 3'b001) begin
         n_bad++;
         $display("FAIL rm_idle got busy=%b O=%b want 0 001", busy, o);
      end
   endtask

   initial begin
      test_reset();
      test_all_yes();
      test_back_to_back();
      test_staggered();
      test_first_wins();
`ifdef VOTE_TIMEOUT_EN
      test_timeout();
      test_full_on_timeout();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
